// File: rtl/gravity_ticker_if.sv
// Bundle between the game controller and the gravity/lock-delay timer.
//   gamespeed    gravity period in clock cycles
//   soft_drop    level, player holds down (period / 8)
//   pause        level, freezes the timer and suppresses pulses
//   spawn        pulse, a new piece appeared at the top of the board
//   landed       level, the active piece rests on the stack or floor
//   moved        pulse, the active piece shifted or rotated
//   drop_tick    1-cycle pulse, move the piece down one row
//   lock_pulse   1-cycle pulse, freeze the piece into the board
//   lock_pending high while the lock delay is running
// master: game controller side; slave: gravity_ticker side.
interface gravity_ticker_if;
  logic [23:0] gamespeed;
  logic        soft_drop;
  logic        pause;
  logic        spawn;
  logic        landed;
  logic        moved;
  logic        drop_tick;
  logic        lock_pulse;
  logic        lock_pending;

  modport master (
    output gamespeed, soft_drop, pause, spawn, landed, moved,
    input  drop_tick, lock_pulse, lock_pending
  );

  modport slave (
    input  gamespeed, soft_drop, pause, spawn, landed, moved,
    output drop_tick, lock_pulse, lock_pending
  );
endinterface

// File: rtl/gravity_ticker.sv
// Falling-piece gravity timer and lock-delay controller.
// Counts gamespeed-derived periods while a piece falls and emits drop_tick,
// then runs a lock delay once the piece lands and emits lock_pulse.
// Ports:
//   clk_25_175  sole clock
//   reset       synchronous, active-low
//   bus         gravity_ticker_if.slave (speed, player/board events, pulses)
module gravity_ticker #(
  parameter logic [23:0] LOCK_CYCLES = 24'd12_587_500,
  parameter logic [3:0]  MAX_RESETS  = 4'd15,
  parameter logic [23:0] MIN_PERIOD  = 24'd1024
) (
  input logic             clk_25_175,
  input logic             reset,
  gravity_ticker_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StFall, StLock} state_e;

  state_e      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [23:0] lock_cnt_q, lock_cnt_d;
  logic [3:0]  resets_used_q, resets_used_d;
  logic        drop_tick_q, drop_tick_d;
  logic        lock_pulse_q, lock_pulse_d;
  logic        lock_pending_q, lock_pending_d;

  logic [23:0] raw_period, period;
  logic        active;
  logic        drop_due, lock_due, restart_ok;

  always_comb begin
    raw_period = bus.soft_drop ? (bus.gamespeed >> 3) : bus.gamespeed;
    period     = (raw_period < MIN_PERIOD) ? MIN_PERIOD : raw_period;
  end

  // pause masks everything, spawn pre-empts every state-local event
  assign active     = !bus.pause && !bus.spawn;
  // >= lets a shrinking period fire on the next edge instead of wrapping
  assign drop_due   = cnt_q >= (period - 24'd1);
  assign lock_due   = lock_cnt_q == (LOCK_CYCLES - 24'd1);
  assign restart_ok = bus.moved && (resets_used_q < MAX_RESETS);

  // State register
  always_ff @(posedge clk_25_175) begin
    if (!reset) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      lock_cnt_q     <= '0;
      resets_used_q  <= '0;
      drop_tick_q    <= 1'b0;
      lock_pulse_q   <= 1'b0;
      lock_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      lock_cnt_q     <= lock_cnt_d;
      resets_used_q  <= resets_used_d;
      drop_tick_q    <= drop_tick_d;
      lock_pulse_q   <= lock_pulse_d;
      lock_pending_q <= lock_pending_d;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    lock_cnt_d    = lock_cnt_q;
    resets_used_d = resets_used_q;
    if (bus.pause) begin
      // hold everything
    end else if (bus.spawn) begin
      state_d       = StFall;
      cnt_d         = '0;
      lock_cnt_d    = '0;
      resets_used_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          cnt_d         = '0;
          lock_cnt_d    = '0;
          resets_used_d = '0;
        end
        StFall: begin
          if (bus.landed) begin
            state_d    = StLock;
            cnt_d      = '0;
            lock_cnt_d = '0;
          end else if (drop_due) begin
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 24'd1;
          end
        end
        StLock: begin
          if (!bus.landed) begin
            // slid off a ledge: resume falling, restart budget carries over
            state_d    = StFall;
            cnt_d      = '0;
            lock_cnt_d = '0;
          end else if (restart_ok) begin
            lock_cnt_d    = '0;
            resets_used_d = resets_used_q + 4'd1;
          end else if (lock_due) begin
            state_d    = StIdle;
            lock_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + 24'd1;
          end
        end
        default: begin
          state_d       = StIdle;
          cnt_d         = '0;
          lock_cnt_d    = '0;
          resets_used_d = '0;
        end
      endcase
    end
  end

  // Output decode (registered one edge later)
  always_comb begin
    drop_tick_d    = active && (state_q == StFall) && !bus.landed && drop_due;
    lock_pulse_d   = active && (state_q == StLock) && bus.landed && !restart_ok && lock_due;
    lock_pending_d = (state_d == StLock);
  end

  assign bus.drop_tick    = drop_tick_q;
  assign bus.lock_pulse   = lock_pulse_q;
  assign bus.lock_pending = lock_pending_q;

endmodule

// File: tb/tb_gravity_ticker.sv
// Self-checking bench for gravity_ticker: directed scenarios with measured
// intervals, then randomized traffic, all checked against a behavioural model.
module tb_gravity_ticker;
  localparam int LockCycles = 8;
  localparam int MaxResets  = 2;
  localparam int MinPeriod  = 4;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  gravity_ticker_if bus ();

  gravity_ticker #(
    .LOCK_CYCLES(24'd8),
    .MAX_RESETS (4'd2),
    .MIN_PERIOD (24'd4)
  ) dut (
    .clk_25_175(clk),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: 0 idle, 1 falling, 2 lock delay
  int m_mode, m_since_drop, m_lock_age, m_restarts;
  bit m_drop, m_lockp, m_pend;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int eff_period();
    int p;
    p = bus.soft_drop ? (int'(bus.gamespeed) / 8) : int'(bus.gamespeed);
    return (p < MinPeriod) ? MinPeriod : p;
  endfunction

  task automatic model_edge();
    m_drop  = 0;
    m_lockp = 0;
    if (!reset) begin
      m_mode = 0; m_since_drop = 0; m_lock_age = 0; m_restarts = 0;
    end else if (bus.pause) begin
      // frozen
    end else if (bus.spawn) begin
      m_mode = 1; m_since_drop = 0; m_lock_age = 0; m_restarts = 0;
    end else if (m_mode == 1) begin
      if (bus.landed) begin
        m_mode = 2; m_lock_age = 0; m_since_drop = 0;
      end else if (m_since_drop + 1 >= eff_period()) begin
        m_drop = 1; m_since_drop = 0;
      end else begin
        m_since_drop++;
      end
    end else if (m_mode == 2) begin
      if (!bus.landed) begin
        m_mode = 1; m_since_drop = 0; m_lock_age = 0;
      end else if (bus.moved && m_restarts < MaxResets) begin
        m_lock_age = 0; m_restarts++;
      end else if (m_lock_age + 1 == LockCycles) begin
        m_lockp = 1; m_mode = 0; m_lock_age = 0;
      end else begin
        m_lock_age++;
      end
    end
    m_pend = (m_mode == 2);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("drop_tick", bus.drop_tick, m_drop);
    check("lock_pulse", bus.lock_pulse, m_lockp);
    check("lock_pending", bus.lock_pending, m_pend);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Edges until drop_tick is seen (bounded); compares against the expected count
  task automatic edges_to_drop(input string tag, input int exp);
    int n = 0;
    bit seen = 0;
    while (!seen && n < exp + 40) begin
      step();
      n++;
      seen = bus.drop_tick;
    end
    check(tag, n, exp);
  endtask

  task automatic edges_to_lock(input string tag, input int exp);
    int n = 0;
    bit seen = 0;
    while (!seen && n < exp + 40) begin
      step();
      n++;
      seen = bus.lock_pulse;
    end
    check(tag, n, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    bus.gamespeed = 24'd20;
    bus.soft_drop = 0; bus.pause = 0; bus.spawn = 0; bus.landed = 0; bus.moved = 0;
    m_mode = 0; m_since_drop = 0; m_lock_age = 0; m_restarts = 0;
    m_drop = 0; m_lockp = 0; m_pend = 0;

    // Reset, then idle without spawn: nothing happens
    steps(3);
    check("rst_drop", bus.drop_tick, 0);
    check("rst_pending", bus.lock_pending, 0);
    reset = 1'b1;
    steps(30);

    // Normal gravity
    bus.spawn = 1; step(); bus.spawn = 0;
    edges_to_drop("first_drop", 20);
    edges_to_drop("period20", 20);

    // Soft drop
    bus.soft_drop = 1;
    edges_to_drop("soft_min4", 4);
    bus.gamespeed = 24'd100;
    edges_to_drop("soft_12", 12);
    bus.soft_drop = 0;
    bus.gamespeed = 24'd20;
    edges_to_drop("back20", 20);

    // Period shrinks under a large count
    steps(15);
    bus.gamespeed = 24'd10;
    step();
    check("shrink_fire", bus.drop_tick, 1);
    edges_to_drop("period10", 10);
    bus.gamespeed = 24'd20;

    // Plain lock delay
    bus.landed = 1; step();
    check("pending_on", bus.lock_pending, 1);
    edges_to_lock("lock8", 8);
    step();
    check("idle_after_lock", bus.lock_pending, 0);

    // Lock restarts: two honoured, third ignored
    bus.landed = 0; bus.spawn = 1; step(); bus.spawn = 0;
    steps(3);
    bus.landed = 1; step();
    steps(5);
    bus.moved = 1; step(); bus.moved = 0;
    steps(5);
    bus.moved = 1; step(); bus.moved = 0;
    steps(2);
    bus.moved = 1; step(); bus.moved = 0;
    edges_to_lock("lock_resets", 5);

    // Pause in FALL and LOCK
    bus.landed = 0; bus.spawn = 1; step(); bus.spawn = 0;
    steps(5);
    bus.pause = 1; bus.spawn = 1; steps(10); bus.spawn = 0; bus.pause = 0;
    edges_to_drop("after_pause", 15);
    bus.landed = 1; step();
    steps(3);
    bus.pause = 1; steps(10); bus.pause = 0;
    check("pause_pending", bus.lock_pending, 1);
    edges_to_lock("lock_after_pause", 5);

    // Spawn during LOCK
    bus.landed = 0; bus.spawn = 1; step(); bus.spawn = 0;
    bus.landed = 1; steps(2);
    bus.spawn = 1; step(); bus.spawn = 0;
    check("spawn_in_lock", bus.lock_pending, 0);
    bus.landed = 0;
    edges_to_drop("spawn_restart", 20);

    // Reset mid-LOCK
    bus.landed = 1; steps(3);
    reset = 1'b0; step(); reset = 1'b1;
    check("reset_in_lock", bus.lock_pending, 0);
    bus.landed = 0;
    steps(25);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus.gamespeed = 24'($urandom_range(0, 40));
      if ($urandom_range(0, 9) == 0) bus.soft_drop = ~bus.soft_drop;
      if ($urandom_range(0, 7) == 0) bus.landed = ~bus.landed;
      bus.pause = ($urandom_range(0, 9) == 0);
      bus.spawn = ($urandom_range(0, 39) == 0);
      bus.moved = ($urandom_range(0, 4) == 0);
      reset     = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
